// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmit path.
package ps2_pkg;

  // Transmit FSM states, in transfer order.
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE,
    FINISH
  } ps2_tx_state_e;

  // Completion codes reported alongside done.
  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_NACK     = 2'b01;
  localparam logic [1:0] ST_START_TO = 2'b10;
  localparam logic [1:0] ST_XFER_TO  = 2'b11;

  // Convert a duration in microseconds into system clock cycles.
  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return (clk_hz / 32'd1_000_000) * us;
  endfunction

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizer and falling-edge detector for one open-drain PS/2 line.
// The line idles high, so every stage resets to 1 to avoid a spurious fall.
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw pin through the synchronizer, then keep one extra copy for edge detection.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign fall_o  = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Drives the shared clock/data lines
// as open-drain enables and holds off the receive decoder while busy.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
  parameter int unsigned INHIBIT_US       = 120,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned XFER_TIMEOUT_US  = 2000,
  parameter int          SYNC_STAGES      = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       done,
  output logic [1:0] status,
  output logic       rx_inhibit,
  input  logic       ps2_clock_i,
  input  logic       ps2_data_i,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_CYC   = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned START_CYC = us_to_cycles(CLK_FREQ_HZ, START_TIMEOUT_US);
  localparam int unsigned XFER_CYC  = us_to_cycles(CLK_FREQ_HZ, XFER_TIMEOUT_US);
  localparam int unsigned MAX_A     = (INH_CYC > START_CYC) ? INH_CYC : START_CYC;
  localparam int unsigned MAX_CYC   = (MAX_A > XFER_CYC) ? MAX_A : XFER_CYC;
  localparam int          TIMER_W   = $clog2(MAX_CYC) + 1;

  // Terminal timer values: a phase of N cycles ends when the timer shows N-1.
  localparam logic [TIMER_W-1:0] INH_PRE    = TIMER_W'(INH_CYC - 2);
  localparam logic [TIMER_W-1:0] INH_LAST   = TIMER_W'(INH_CYC - 1);
  localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_CYC - 1);
  localparam logic [TIMER_W-1:0] XFER_LAST  = TIMER_W'(XFER_CYC - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  ps2_tx_state_e      state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic               clk_oe_q, clk_oe_d;
  logic               dat_oe_q, dat_oe_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [1:0]         status_q, status_d;
  logic               inhibit_q, inhibit_d;
  logic               nack_q, nack_d;
  logic [8:0]         shift_q;
  logic               load_shift;

  logic clk_level, clk_fall;
  logic dat_level, dat_fall_unused;
  logic xfer_expired;

  ps2_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_clk_sync (
    .clock_i (clock),
    .reset_ni(reset_n),
    .line_i  (ps2_clock_i),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_dat_sync (
    .clock_i (clock),
    .reset_ni(reset_n),
    .line_i  (ps2_data_i),
    .level_o (dat_level),
    .fall_o  (dat_fall_unused)
  );

  // The whole device-clocked phase shares one budget measured from the first device fall.
  assign xfer_expired = (timer_q >= XFER_LAST);

  // Next-state and next-output decode for the transmit sequence.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    status_d   = status_q;
    inhibit_d  = inhibit_q;
    nack_d     = nack_q;
    load_shift = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (tx_valid) begin
          load_shift = 1'b1;
          bit_cnt_d  = 4'd0;
          timer_d    = '0;
          inhibit_d  = 1'b1;
          ready_d    = 1'b0;
          clk_oe_d   = 1'b1;
          dat_oe_d   = 1'b0;
          nack_d     = 1'b0;
          state_d    = INHIBIT;
        end
      end

      INHIBIT: begin
        timer_d = timer_q + TIMER_ONE;
        // Pull data low (start bit) one cycle before the clock is let go.
        if (timer_q == INH_PRE) begin
          dat_oe_d = 1'b1;
        end
        if (timer_q == INH_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          timer_d  = '0;
          state_d  = REQ;
        end
      end

      REQ: begin
        timer_d = timer_q + TIMER_ONE;
        if (clk_fall) begin
          dat_oe_d = ~shift_q[0];
          timer_d  = '0;
          state_d  = SEND;
        end else if (timer_q >= START_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          done_d   = 1'b1;
          status_d = ST_START_TO;
          state_d  = FINISH;
        end
      end

      SEND: begin
        timer_d = timer_q + TIMER_ONE;
        if (xfer_expired) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          done_d   = 1'b1;
          status_d = ST_XFER_TO;
          state_d  = FINISH;
        end else if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) begin
            // Stop bit: release data and let the device pull it for ACK.
            dat_oe_d = 1'b0;
            state_d  = ACK;
          end else begin
            dat_oe_d = ~shift_q[bit_cnt_q + 4'd1];
          end
        end
      end

      ACK: begin
        timer_d = timer_q + TIMER_ONE;
        if (xfer_expired) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          done_d   = 1'b1;
          status_d = ST_XFER_TO;
          state_d  = FINISH;
        end else if (clk_fall) begin
          // Device acknowledges by holding data low across this fall.
          nack_d  = dat_level;
          state_d = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        timer_d = timer_q + TIMER_ONE;
        if (xfer_expired) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          done_d   = 1'b1;
          status_d = ST_XFER_TO;
          state_d  = FINISH;
        end else if (clk_level && dat_level) begin
          done_d   = 1'b1;
          status_d = nack_q ? ST_NACK : ST_OK;
          state_d  = FINISH;
        end
      end

      FINISH: begin
        clk_oe_d  = 1'b0;
        dat_oe_d  = 1'b0;
        timer_d   = '0;
        ready_d   = 1'b1;
        inhibit_d = 1'b0;
        state_d   = IDLE;
      end

      default: begin
        clk_oe_d  = 1'b0;
        dat_oe_d  = 1'b0;
        ready_d   = 1'b1;
        inhibit_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // FSM state, timers and all registered outputs; reset releases both lines at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= 4'd0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      status_q  <= ST_OK;
      inhibit_q <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      status_q  <= status_d;
      inhibit_q <= inhibit_d;
      nack_q    <= nack_d;
    end
  end

  // Frame register: parity above the data byte, captured only at acceptance.
  always_ff @(posedge clock) begin
    if (load_shift) begin
      shift_q <= {odd_parity(tx_data), tx_data};
    end
  end

  assign tx_ready     = ready_q;
  assign done         = done_q;
  assign status       = status_q;
  assign rx_inhibit   = inhibit_q;
  assign ps2_clock_oe = clk_oe_q;
  assign ps2_data_oe  = dat_oe_q;

endmodule
